sa_weight_sequencer: RTL
========================

Name: sa_weight_sequencer

Overview:
- Sits between the register file and the systolic array (SA).
- Snapshots the weight matrix, bias matrix and layer info when the register file pulses weight_ov, bias_ov and layer_info_ov.
- On the send-systolic-data pulse, shifts weight rows into the SA bottom-row-first under SA backpressure, presents the bias row, starts the array and waits for completion.
- Returns a single-cycle done pulse that releases the register file's PC stall (received_SA_od).

Parameters:
- HEIGHT, 8, SA rows and maximum weight height
- WIDTH, 8, SA columns and maximum weight width
- DATA_WIDTH, 8, bits per weight/bias element
- TIMEOUT, 1024, maximum cycles in RUN before forced abort

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- weight_iv  in  1  pulse: capture weight_id
- weight_id  in  HEIGHT*WIDTH*DATA_WIDTH  weight matrix, [row][col][bit] packed
- bias_iv  in  1  pulse: capture bias_id
- bias_id  in  HEIGHT*WIDTH*DATA_WIDTH  bias matrix
- layer_info_iv  in  1  pulse: capture the dimension and op inputs
- weight_height_id  in  4  weight rows
- weight_width_id  in  4  weight columns
- bias_width_id  in  4  bias columns
- op_id  in  3  {reLU_sel, op_sel, flatten}; op_sel 0=CONV, 1=MUL
- start_iv  in  1  pulse from register file send_sd
- sa_weight_ov  out  1  weight row valid
- sa_weight_od  out  WIDTH*DATA_WIDTH  current weight row
- sa_weight_idx_od  out  $clog2(HEIGHT)  row index of sa_weight_od
- sa_weight_ready_i  in  1  SA accepts row this cycle
- sa_bias_ov  out  1  bias row valid, one cycle
- sa_bias_od  out  WIDTH*DATA_WIDTH  bias row
- sa_start_ov  out  1  one-cycle start pulse to SA
- sa_done_iv  in  1  SA finished computation
- done_ov  out  1  one-cycle completion pulse (drives received_SA_od)
- busy_o  out  1  high in any state other than IDLE
- err_o  out  1  one-cycle error pulse

Behaviour:
- Reset (rst high at a clock edge): state IDLE; all outputs 0; valid flags w_vld, b_vld, i_vld cleared; buffers cleared. rst mid-operation aborts immediately; no done_ov is issued.
- Capture: in IDLE, weight_iv/bias_iv/layer_info_iv latch their inputs on the same edge and set the matching flag; simultaneous pulses all capture. A capture pulse outside IDLE is ignored and pulses err_o.
- States: IDLE -> LOAD_ROWS -> SEND_BIAS -> RUN -> DONE -> IDLE.
- IDLE: start_iv with all three flags set and 1<=weight_height<=HEIGHT and 1<=weight_width<=WIDTH -> LOAD_ROWS with row_cnt=weight_height-1. Otherwise start_iv pulses err_o next cycle and the state stays IDLE. Entry into LOAD_ROWS registers sa_weight_ov=1 on the following cycle.
- LOAD_ROWS:
  - sa_weight_ov=1; sa_weight_od = weight row row_cnt with columns >= weight_width forced to 0; sa_weight_idx_od = row_cnt.
  - On sa_weight_ready_i, decrement row_cnt; row 0 accepted -> SEND_BIAS.
  - Without ready, row and index hold stable.
  - Latency = weight_height cycles minimum.
- SEND_BIAS: one cycle, sa_bias_ov=1.
  - CONV: every column < weight_width carries bias[0][0]; other columns 0.
  - MUL: column c carries bias[0][c] for c < bias_width; other columns 0.
  - Next state RUN.
- RUN:
  - sa_start_ov=1 on the first RUN cycle only; timer counts from 0.
  - sa_done_iv -> DONE. sa_done_iv during the first RUN cycle is accepted.
  - Timer reaching TIMEOUT-1 without done -> DONE, with err_o pulsed together with done_ov.
- DONE: done_ov=1 for one cycle; clear w_vld, b_vld, i_vld; -> IDLE.
- Ignored inputs: start_iv outside IDLE; sa_done_iv outside RUN.
- Outputs are registered except sa_weight_od and sa_weight_idx_od, which are combinational from the buffer and row_cnt.

Test Plan:
- Basic MUL pass: load 3x2 weights W[i][j]=10*i+j, bias row {5,6}, op=010, start, ready always 1 -> rows 2,1,0 presented on consecutive cycles; row 2 = {20,21,0,...}; bias {5,6,0,...}; one sa_start_ov; sa_done 4 cycles later -> one done_ov.
- Backpressure: 2x2 weights with ready low for 3 cycles on row 1 -> row 1 and index held 3 cycles; no rows skipped; total weight phase 5 cycles.
- CONV bias: bias[0][0]=0x7F, weight_width=3, op_sel=0 -> sa_bias_od columns 0..2 = 0x7F, others 0.
- Missing info: start_iv with only weights loaded -> err_o pulse, busy_o stays 0, no SA outputs. weight_height=0 -> same response.
- Timeout: TIMEOUT=16, never assert sa_done -> done_ov and err_o together 16 cycles after sa_start_ov; flags cleared; a second start without reloading -> err_o.
- Reset mid-LOAD_ROWS: assert rst during row 1 -> next cycle all outputs 0, IDLE; a following start without reloading -> err_o.

Source files
------------

// File: rtl/sa_weight_sequencer.sv
// sa_weight_sequencer: snapshots weight/bias/layer info from the register file,
// streams weight rows into the systolic array bottom-row-first under
// backpressure, presents the bias row, starts the array and reports completion.
module sa_weight_sequencer #(
  parameter int HEIGHT     = 8,
  parameter int WIDTH      = 8,
  parameter int DATA_WIDTH = 8,
  parameter int TIMEOUT    = 1024,
  localparam int IDX_W     = (HEIGHT > 1) ? $clog2(HEIGHT) : 1
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               weight_iv,
  input  logic [HEIGHT*WIDTH*DATA_WIDTH-1:0] weight_id,
  input  logic                               bias_iv,
  input  logic [HEIGHT*WIDTH*DATA_WIDTH-1:0] bias_id,
  input  logic                               layer_info_iv,
  input  logic [3:0]                         weight_height_id,
  input  logic [3:0]                         weight_width_id,
  input  logic [3:0]                         bias_width_id,
  input  logic [2:0]                         op_id,
  input  logic                               start_iv,
  output logic                               sa_weight_ov,
  output logic [WIDTH*DATA_WIDTH-1:0]        sa_weight_od,
  output logic [IDX_W-1:0]                   sa_weight_idx_od,
  input  logic                               sa_weight_ready_i,
  output logic                               sa_bias_ov,
  output logic [WIDTH*DATA_WIDTH-1:0]        sa_bias_od,
  output logic                               sa_start_ov,
  input  logic                               sa_done_iv,
  output logic                               done_ov,
  output logic                               busy_o,
  output logic                               err_o
);

  localparam int ROW_W = WIDTH * DATA_WIDTH;
  localparam int MAT_W = HEIGHT * ROW_W;
  localparam int TMR_W = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD_ROWS,
    S_SEND_BIAS,
    S_RUN,
    S_DONE
  } state_t;

  state_t             state_q, state_d;
  logic [MAT_W-1:0]   weight_q, weight_d;
  logic [MAT_W-1:0]   bias_q, bias_d;
  logic [3:0]         weight_height_q, weight_height_d;
  logic [3:0]         weight_width_q, weight_width_d;
  logic [3:0]         bias_width_q, bias_width_d;
  logic [2:0]         op_q, op_d;
  logic               w_vld_q, w_vld_d;
  logic               b_vld_q, b_vld_d;
  logic               i_vld_q, i_vld_d;
  logic [IDX_W-1:0]   row_cnt_q, row_cnt_d;
  logic [TMR_W-1:0]   timer_q, timer_d;
  logic               sa_weight_ov_q, sa_weight_ov_d;
  logic               sa_bias_ov_q, sa_bias_ov_d;
  logic [ROW_W-1:0]   sa_bias_od_q, sa_bias_od_d;
  logic               sa_start_ov_q, sa_start_ov_d;
  logic               done_ov_q, done_ov_d;
  logic               busy_q, busy_d;
  logic               err_q, err_d;

  logic [ROW_W-1:0]   weight_row;
  logic [ROW_W-1:0]   weight_row_masked;
  logic [ROW_W-1:0]   bias_row;
  logic               dims_ok;

  // Select the current weight row and zero the columns beyond the layer width
  always_comb begin
    weight_row        = weight_q[int'(row_cnt_q) * ROW_W +: ROW_W];
    weight_row_masked = '0;
    for (int c = 0; c < WIDTH; c++) begin
      if (c < int'(weight_width_q)) begin
        weight_row_masked[c*DATA_WIDTH +: DATA_WIDTH] = weight_row[c*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  // Build the bias row: CONV broadcasts bias[0][0], MUL passes row 0 through
  always_comb begin
    bias_row = '0;
    for (int c = 0; c < WIDTH; c++) begin
      if (op_q[1] == 1'b0) begin
        if (c < int'(weight_width_q)) begin
          bias_row[c*DATA_WIDTH +: DATA_WIDTH] = bias_q[DATA_WIDTH-1:0];
        end
      end else begin
        if (c < int'(bias_width_q)) begin
          bias_row[c*DATA_WIDTH +: DATA_WIDTH] = bias_q[c*DATA_WIDTH +: DATA_WIDTH];
        end
      end
    end
  end

  // Sequencer next-state logic: captures, row streaming, bias, run timer, done
  always_comb begin
    state_d         = state_q;
    weight_d        = weight_q;
    bias_d          = bias_q;
    weight_height_d = weight_height_q;
    weight_width_d  = weight_width_q;
    bias_width_d    = bias_width_q;
    op_d            = op_q;
    w_vld_d         = w_vld_q;
    b_vld_d         = b_vld_q;
    i_vld_d         = i_vld_q;
    row_cnt_d       = row_cnt_q;
    timer_d         = timer_q;
    sa_weight_ov_d  = sa_weight_ov_q;
    sa_bias_ov_d    = 1'b0;
    sa_bias_od_d    = '0;
    sa_start_ov_d   = 1'b0;
    done_ov_d       = 1'b0;
    err_d           = 1'b0;

    dims_ok = (weight_height_q != 4'd0) && (int'(weight_height_q) <= HEIGHT) &&
              (weight_width_q != 4'd0) && (int'(weight_width_q) <= WIDTH);

    if (state_q != S_IDLE && (weight_iv || bias_iv || layer_info_iv)) begin
      err_d = 1'b1;
    end

    case (state_q)
      S_IDLE: begin
        if (weight_iv) begin
          weight_d = weight_id;
          w_vld_d  = 1'b1;
        end
        if (bias_iv) begin
          bias_d  = bias_id;
          b_vld_d = 1'b1;
        end
        if (layer_info_iv) begin
          weight_height_d = weight_height_id;
          weight_width_d  = weight_width_id;
          bias_width_d    = bias_width_id;
          op_d            = op_id;
          i_vld_d         = 1'b1;
        end
        if (start_iv) begin
          if (w_vld_q && b_vld_q && i_vld_q && dims_ok) begin
            state_d        = S_LOAD_ROWS;
            row_cnt_d      = IDX_W'(weight_height_q - 4'd1);
            sa_weight_ov_d = 1'b1;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      S_LOAD_ROWS: begin
        if (sa_weight_ready_i) begin
          if (row_cnt_q == '0) begin
            state_d        = S_SEND_BIAS;
            sa_weight_ov_d = 1'b0;
            sa_bias_ov_d   = 1'b1;
            sa_bias_od_d   = bias_row;
          end else begin
            row_cnt_d = row_cnt_q - 1'b1;
          end
        end
      end
      S_SEND_BIAS: begin
        state_d       = S_RUN;
        sa_start_ov_d = 1'b1;
        timer_d       = '0;
      end
      S_RUN: begin
        if (sa_done_iv) begin
          state_d   = S_DONE;
          done_ov_d = 1'b1;
        end else if (timer_q == TMR_W'(TIMEOUT - 1)) begin
          state_d   = S_DONE;
          done_ov_d = 1'b1;
          err_d     = 1'b1;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      S_DONE: begin
        w_vld_d = 1'b0;
        b_vld_d = 1'b0;
        i_vld_d = 1'b0;
        state_d = S_IDLE;
      end
      default: begin
        state_d        = S_IDLE;
        sa_weight_ov_d = 1'b0;
      end
    endcase

    busy_d = (state_d != S_IDLE);
  end

  // State and registered outputs, cleared by synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q         <= S_IDLE;
      weight_q        <= '0;
      bias_q          <= '0;
      weight_height_q <= '0;
      weight_width_q  <= '0;
      bias_width_q    <= '0;
      op_q            <= '0;
      w_vld_q         <= 1'b0;
      b_vld_q         <= 1'b0;
      i_vld_q         <= 1'b0;
      row_cnt_q       <= '0;
      timer_q         <= '0;
      sa_weight_ov_q  <= 1'b0;
      sa_bias_ov_q    <= 1'b0;
      sa_bias_od_q    <= '0;
      sa_start_ov_q   <= 1'b0;
      done_ov_q       <= 1'b0;
      busy_q          <= 1'b0;
      err_q           <= 1'b0;
    end else begin
      state_q         <= state_d;
      weight_q        <= weight_d;
      bias_q          <= bias_d;
      weight_height_q <= weight_height_d;
      weight_width_q  <= weight_width_d;
      bias_width_q    <= bias_width_d;
      op_q            <= op_d;
      w_vld_q         <= w_vld_d;
      b_vld_q         <= b_vld_d;
      i_vld_q         <= i_vld_d;
      row_cnt_q       <= row_cnt_d;
      timer_q         <= timer_d;
      sa_weight_ov_q  <= sa_weight_ov_d;
      sa_bias_ov_q    <= sa_bias_ov_d;
      sa_bias_od_q    <= sa_bias_od_d;
      sa_start_ov_q   <= sa_start_ov_d;
      done_ov_q       <= done_ov_d;
      busy_q          <= busy_d;
      err_q           <= err_d;
    end
  end

  assign sa_weight_ov     = sa_weight_ov_q;
  assign sa_weight_od     = sa_weight_ov_q ? weight_row_masked : '0;
  assign sa_weight_idx_od = row_cnt_q;
  assign sa_bias_ov       = sa_bias_ov_q;
  assign sa_bias_od       = sa_bias_od_q;
  assign sa_start_ov      = sa_start_ov_q;
  assign done_ov          = done_ov_q;
  assign busy_o           = busy_q;
  assign err_o            = err_q;

endmodule
